// File: rtl/rx_frame_arbiter.sv
// Frame-granular round-robin arbiter: merges up to four AHIR receive pipes onto one output pipe,
// holding a grant until the frame's last word and aborting a stalled source with a marker word.
module rx_frame_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 37,
  parameter int TIMEOUT = 1024,
  parameter int T_S     = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ*W-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_req,
  output logic [NUM_REQ-1:0]   in_ack,
  output logic [W-1:0]         out_data,
  output logic                 out_req,
  input  logic                 out_ack,
  output logic [15:0]          frame_count,
  output logic [15:0]          abort_count
);

  localparam int GW = $clog2(NUM_REQ);
  // Bad-packet marker: last=1, data=1, keep=0.
  localparam logic [W-1:0] ABORT_WORD = (W'(1) << (W - 1)) | (W'(1) << 4);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [GW-1:0]  grant;
  logic [GW-1:0]  last_grant;
  logic [GW-1:0]  winner;
  logic [GW-1:0]  cand;
  logic           found;
  logic [T_S-1:0] timer;
  logic           buf_valid;
  logic [W-1:0]   buf_word;
  logic [W-1:0]   sel_word;
  logic           sel_req;
  logic           can_load;
  logic           abort_now;
  logic           abort_load;
  logic           accept;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && in_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    sel_req  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == GW'(i)) begin
        sel_word = in_data[i*W +: W];
        sel_req  = in_req[i];
      end
    end
  end

  assign can_load   = !buf_valid || out_ack;
  assign abort_now  = (state == LOCKED) && (timer == T_S'(TIMEOUT));
  assign abort_load = abort_now && can_load;
  assign accept     = (state == LOCKED) && !abort_now && sel_req && can_load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|in_req) state_nxt = LOCKED;
      LOCKED:  if ((accept && sel_word[W-1]) || abort_load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == GW'(i)) in_ack[i] = accept;
    end
  end

  // Grant bookkeeping, idle timer and statistics counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant       <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      timer       <= '0;
      frame_count <= '0;
      abort_count <= '0;
    end else if (state == IDLE) begin
      if (|in_req) grant <= winner;
      timer <= '0;
    end else if (accept) begin
      timer <= '0;
      if (sel_word[W-1]) begin
        last_grant  <= grant;
        frame_count <= frame_count + 16'd1;
      end
    end else if (abort_load) begin
      timer       <= '0;
      last_grant  <= grant;
      frame_count <= frame_count + 16'd1;
      abort_count <= abort_count + 16'd1;
    end else if (!sel_req && (timer != T_S'(TIMEOUT))) begin
      timer <= timer + T_S'(1);
    end
  end

  // Single-entry output buffer; load and drain may coincide for full throughput.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_word  <= sel_word;
    end else if (abort_load) begin
      buf_valid <= 1'b1;
      buf_word  <= ABORT_WORD;
    end else if (out_ack) begin
      buf_valid <= 1'b0;
    end
  end

  assign out_req  = buf_valid;
  assign out_data = buf_word;

endmodule
